// File: rtl/rom_fetch_scheduler_pkg.sv
// Shared types and constants for the ROM fetch scheduler.
// State encoding, mode and requester identifiers.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic MODE_SINGLE = 1'b0;
    localparam logic MODE_QUAD   = 1'b1;

    localparam logic REQ_DISPLAY = 1'b0;
    localparam logic REQ_AUX     = 1'b1;

    // Index of the final ROM beat for a request.
    function automatic logic [1:0] last_beat(input logic quad);
        return (quad == MODE_QUAD) ? 2'd3 : 2'd0;
    endfunction

endpackage

// File: rtl/rom_fetch_scheduler_if.sv
// Requester, ROM and response bus of the ROM fetch scheduler.
// The scheduler sits on the slave modport; requesters/ROM/consumer on master.
interface rom_fetch_scheduler_if #(
    parameter int IMG_WIDTH  = 160,
    parameter int IMG_HEIGHT = 120,
    parameter int DATA_W     = 8
);
    localparam int XW = $clog2(IMG_WIDTH);
    localparam int YW = $clog2(IMG_HEIGHT);
    localparam int AW = $clog2(IMG_WIDTH * IMG_HEIGHT);

    logic              req0_valid;
    logic              req0_ready;
    logic [XW-1:0]     req0_x;
    logic [YW-1:0]     req0_y;
    logic              req0_quad;

    logic              req1_valid;
    logic              req1_ready;
    logic [XW-1:0]     req1_x;
    logic [YW-1:0]     req1_y;
    logic              req1_quad;

    logic [AW-1:0]     rom_addr;
    logic [DATA_W-1:0] rom_data;

    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_id;
    logic              rsp_quad;
    logic              rsp_oob;
    logic [DATA_W-1:0] rsp_p00;
    logic [DATA_W-1:0] rsp_p01;
    logic [DATA_W-1:0] rsp_p10;
    logic [DATA_W-1:0] rsp_p11;

    modport slave (
        input  req0_valid, req0_x, req0_y, req0_quad,
        input  req1_valid, req1_x, req1_y, req1_quad,
        input  rom_data, rsp_ready,
        output req0_ready, req1_ready, rom_addr,
        output rsp_valid, rsp_id, rsp_quad, rsp_oob,
        output rsp_p00, rsp_p01, rsp_p10, rsp_p11
    );

    modport master (
        output req0_valid, req0_x, req0_y, req0_quad,
        output req1_valid, req1_x, req1_y, req1_quad,
        output rom_data, rsp_ready,
        input  req0_ready, req1_ready, rom_addr,
        input  rsp_valid, rsp_id, rsp_quad, rsp_oob,
        input  rsp_p00, rsp_p01, rsp_p10, rsp_p11
    );

endinterface

// File: rtl/rom_fetch_scheduler_rr_arbiter2.sv
// Two-input round-robin arbiter; on contention the requester
// that did not win last time is granted.
module rr_arbiter2
    import fetch_pkg::*;
(
    input  logic [1:0] i_valid,
    input  logic       i_last_grant,
    input  logic       i_enable,
    output logic [1:0] o_grant,
    output logic       o_grant_id
);

    always_comb begin
        o_grant_id = REQ_DISPLAY;
        unique case (i_valid)
            2'b01:   o_grant_id = REQ_DISPLAY;
            2'b10:   o_grant_id = REQ_AUX;
            2'b11:   o_grant_id = ~i_last_grant;
            default: o_grant_id = REQ_DISPLAY;
        endcase

        o_grant = 2'b00;
        if (i_enable && (|i_valid)) begin
            o_grant = (o_grant_id == REQ_AUX) ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/rom_fetch_scheduler.sv
// Arbitrates two requesters onto a 1-cycle-latency ROM, fetches a
// clamped single pixel or 2x2 block, and returns it under valid/ready.
module rom_fetch_scheduler
    import fetch_pkg::*;
#(
    parameter int IMG_WIDTH  = 160,
    parameter int IMG_HEIGHT = 120,
    parameter int DATA_W     = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    rom_fetch_scheduler_if.slave  bus
);

    localparam int XW = $clog2(IMG_WIDTH);
    localparam int YW = $clog2(IMG_HEIGHT);
    localparam int AW = $clog2(IMG_WIDTH * IMG_HEIGHT);

    state_t            r_state;
    state_t            w_next;

    logic [XW-1:0]     r_x;
    logic [YW-1:0]     r_y;
    logic              r_quad;
    logic              r_id;
    logic              r_oob;
    logic              r_last_grant;
    logic [1:0]        r_idx;
    logic [AW-1:0]     r_rom_addr;
    logic [DATA_W-1:0] r_pix [4];

    logic [1:0]        w_grant;
    logic              w_gid;
    logic              w_arb_en;
    logic              w_accept;
    logic [XW-1:0]     w_in_x;
    logic [YW-1:0]     w_in_y;
    logic              w_in_quad;
    logic              w_in_oob;
    logic [AW-1:0]     w_in_addr;
    logic [XW-1:0]     w_xr;
    logic [YW-1:0]     w_yb;
    logic [AW-1:0]     w_addr [4];
    logic [1:0]        w_last_idx;
    logic              w_fetch_done;

    // Wide intermediate keeps row*width+col from wrapping.
    function automatic logic [AW-1:0] addr_of(
        input logic [YW-1:0] row,
        input logic [XW-1:0] col
    );
        logic [AW:0] w_sum;
        w_sum = (AW+1)'(row) * (AW+1)'(IMG_WIDTH)
              + (AW+1)'(col);
        return w_sum[AW-1:0];
    endfunction

    assign w_arb_en = (r_state == IDLE) && reset;

    rr_arbiter2 u_arb (
        .i_valid      ({bus.req1_valid, bus.req0_valid}),
        .i_last_grant (r_last_grant),
        .i_enable     (w_arb_en),
        .o_grant      (w_grant),
        .o_grant_id   (w_gid)
    );

    assign w_accept       = |w_grant;
    assign bus.req0_ready = w_grant[0];
    assign bus.req1_ready = w_grant[1];

    always_comb begin
        w_in_x    = (w_gid == REQ_AUX) ? bus.req1_x : bus.req0_x;
        w_in_y    = (w_gid == REQ_AUX) ? bus.req1_y : bus.req0_y;
        w_in_quad = (w_gid == REQ_AUX) ? bus.req1_quad
                                       : bus.req0_quad;
        w_in_oob  = ({1'b0, w_in_x} >= (XW+1)'(IMG_WIDTH))
                 || ({1'b0, w_in_y} >= (YW+1)'(IMG_HEIGHT));
        w_in_addr = addr_of(w_in_y, w_in_x);
    end

    // Latched coordinates are always in bounds, so +1 cannot overflow.
    always_comb begin
        w_xr = (r_x >= XW'(IMG_WIDTH - 1))
             ? XW'(IMG_WIDTH - 1) : r_x + XW'(1);
        w_yb = (r_y >= YW'(IMG_HEIGHT - 1))
             ? YW'(IMG_HEIGHT - 1) : r_y + YW'(1);
        w_addr[0] = addr_of(r_y, r_x);
        w_addr[1] = addr_of(r_y, w_xr);
        w_addr[2] = addr_of(w_yb, r_x);
        w_addr[3] = addr_of(w_yb, w_xr);
    end

    assign w_last_idx   = last_beat(r_quad);
    assign w_fetch_done = (r_idx == w_last_idx);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next        = r_state;
        bus.rsp_valid = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next = w_in_oob ? RESP : FETCH;
                end
            end
            FETCH: begin
                if (w_fetch_done) begin
                    w_next = WAIT;
                end
            end
            WAIT: begin
                w_next = RESP;
            end
            RESP: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_x          <= '0;
            r_y          <= '0;
            r_quad       <= MODE_SINGLE;
            r_id         <= REQ_DISPLAY;
            r_oob        <= 1'b0;
            r_last_grant <= REQ_AUX;
            r_idx        <= '0;
            r_rom_addr   <= '0;
            for (int i = 0; i < 4; i++) begin
                r_pix[i] <= '0;
            end
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_x          <= w_in_x;
                        r_y          <= w_in_y;
                        r_quad       <= w_in_quad;
                        r_id         <= w_gid;
                        r_last_grant <= w_gid;
                        r_oob        <= w_in_oob;
                        r_idx        <= '0;
                        r_rom_addr   <= w_in_oob ? '0 : w_in_addr;
                        if (w_in_oob) begin
                            for (int i = 0; i < 4; i++) begin
                                r_pix[i] <= '0;
                            end
                        end
                    end
                end
                FETCH: begin
                    // Data returning now belongs to the previous beat.
                    if (r_idx != 2'd0) begin
                        r_pix[r_idx - 2'd1] <= bus.rom_data;
                    end
                    if (w_fetch_done) begin
                        r_rom_addr <= '0;
                    end else begin
                        r_idx      <= r_idx + 2'd1;
                        r_rom_addr <= w_addr[r_idx + 2'd1];
                    end
                end
                WAIT: begin
                    if (r_quad == MODE_QUAD) begin
                        r_pix[3] <= bus.rom_data;
                    end else begin
                        for (int i = 0; i < 4; i++) begin
                            r_pix[i] <= bus.rom_data;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.rom_addr = r_rom_addr;
    assign bus.rsp_id   = r_id;
    assign bus.rsp_quad = r_quad;
    assign bus.rsp_oob  = r_oob;
    assign bus.rsp_p00  = r_pix[0];
    assign bus.rsp_p01  = r_pix[1];
    assign bus.rsp_p10  = r_pix[2];
    assign bus.rsp_p11  = r_pix[3];

endmodule

// File: doc/rom_fetch_scheduler.md
Name: rom_fetch_scheduler

Overview:
Sequences all accesses to the single-port, 1-cycle-latency image ROM.
- Two requesters share the ROM: port 0 is the display path and port 1 is a secondary consumer such as a filter or readback path.
- Each request asks for either one pixel (single) or a 2x2 block (quad) at source coordinates (x,y).
- The block arbitrates round-robin, generates the ROM addresses with edge clamping, gathers the returned data, and presents a 4-pixel response under a valid/ready handshake.

Parameters:
- IMG_WIDTH, 160, source image width in pixels.
- IMG_HEIGHT, 120, source image height in pixels.
- DATA_W, 8, pixel width in bits.
- Derived localparams: XW=$clog2(IMG_WIDTH), YW=$clog2(IMG_HEIGHT), AW=$clog2(IMG_WIDTH*IMG_HEIGHT).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- req0_valid / req1_valid  in  1  request pending.
- req0_ready / req1_ready  out  1  request accepted this cycle.
- req0_x / req1_x  in  XW  source x.
- req0_y / req1_y  in  YW  source y.
- req0_quad / req1_quad  in  1  1 = 2x2 block, 0 = single pixel.
- rom_addr  out  AW  ROM address, registered.
- rom_data  in  DATA_W  ROM read data, valid one cycle after the address.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer takes response.
- rsp_id  out  1  requester that owns the response.
- rsp_quad  out  1  echo of the request's quad field.
- rsp_oob  out  1  request coordinates were out of bounds.
- rsp_p00, rsp_p01, rsp_p10, rsp_p11  out  DATA_W each  pixels (row,col).

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - All outputs 0, including rom_addr and the rsp_* fields.
  - last_grant=1, so req0 wins the first contention.
  - Reset mid-operation aborts the transaction; no response is produced.
- Arbitration (IDLE only):
  - reqN_ready = IDLE && granted(N), combinational.
  - If exactly one requester is valid, it is granted.
  - If both are valid, grant the one not equal to last_grant.
  - On acceptance: latch x, y, quad and id; update last_grant.
  - reqN_ready is 0 in every other state.
- Bounds: if x>=IMG_WIDTH or y>=IMG_HEIGHT at acceptance, go directly to RESP with rsp_oob=1 and all pixels 0. No ROM access is made.
- Addressing: addr(r,c) = r*IMG_WIDTH + c.
  - xr = min(x+1, IMG_WIDTH-1); yb = min(y+1, IMG_HEIGHT-1).
  - Issue order is A00=(y,x), A01=(y,xr), A10=(yb,x), A11=(yb,xr).
  - Arithmetic is done at AW+1 bits and truncated; there is no wrap.
- States:
  - IDLE: rom_addr=0.
  - FETCH: counter idx runs 0..N-1, with N=4 for quad and N=1 for single. rom_addr = address[idx].
  - WAIT: one cycle to capture the last datum.
  - RESP: rsp_valid=1.
- Data capture: rom_data in the cycle after address[k] is presented is stored in pixel slot k.
- Single mode: p01, p10 and p11 replicate p00.
- Latency, with the accept handshake in cycle 0:
  - Quad: rom_addr=A00 in cycle 1 … A11 in cycle 4. rsp_valid is first high in cycle 6.
  - Single: rom_addr=A00 in cycle 1. rsp_valid is first high in cycle 3.
  - OOB: rsp_valid is first high in cycle 1.
- RESP:
  - All rsp_* fields are held stable while rsp_valid && !rsp_ready.
  - When rsp_ready=1, the next state is IDLE (one bubble cycle), and rsp_valid drops.
  - rsp_* data fields keep their last values and are don't-care when rsp_valid=0.
- Requester inputs that change after acceptance have no effect on the transaction in flight.
- req_valid deasserting without a handshake is legal and is simply ignored.

Decomposition:
- Shared package fetch_pkg holds:
  - State encoding: IDLE, FETCH, WAIT, RESP.
  - Mode constants: MODE_SINGLE=0, MODE_QUAD=1.
  - Requester IDs: REQ_DISPLAY=0, REQ_AUX=1.
- Sub-module rr_arbiter2: two-input round-robin arbiter.
  - Inputs: valids, last_grant, enable.
  - Outputs: grant vector and grant id.

Test Plan:
1. Quad: req0 (x=10, y=5, quad) with ROM data = addr[7:0] -> rom_addr sequence 810, 811, 970, 971 in cycles 1-4; rsp_valid in cycle 6; p00=0x2A, p01=0x2B, p10=0xCA, p11=0xCB; rsp_id=0.
2. Corner clamp: req1 (x=159, y=119, quad) -> all four addresses are 19199; all pixels equal; rsp_id=1.
3. Contention: req0 and req1 both valid every cycle with rsp_ready=1 -> grants alternate 0,1,0,1 after reset; neither requester waits more than one transaction.
4. OOB: req0 (x=160, y=0) -> no FETCH cycles; rsp_valid in cycle 1; rsp_oob=1; pixels 0.
5. Backpressure: single request (x=3, y=2), rsp_ready held 0 for 5 cycles -> rom_addr=323 in cycle 1; rsp fields stable for all 5 cycles; req_ready stays 0; accept proceeds after rsp_ready rises.
6. Reset mid-FETCH: reset=0 in cycle 3 of a quad -> rsp_valid and rom_addr become 0 immediately; after release, no stale response appears and req0 wins the first contention.
